ov7670_cfg_sequencer: RTL and testbench



---
 rtl/ov7670_cfg_sequencer.sv | 158 +++++++++++++++
 tb/tb_ov7670_cfg_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 register-table sequencer: walks a {reg,data} ROM and issues one SCCB write per entry.
// Define CFG_READBACK_EN to verify every write with a read of the same register.
module ov7670_cfg_sequencer #(
  parameter int unsigned ROM_AW     = 8,
  parameter int unsigned DELAY_UNIT = 500000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_req,
  input  logic              sccb_ready,
  output logic              sccb_rw,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_wdata,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  input  logic [7:0]        sccb_rdata,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [ROM_AW-1:0] err_index
);

  localparam int unsigned CNT_W = $clog2(255 * DELAY_UNIT + 1);
  localparam int unsigned RET_W = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [RET_W-1:0] retries;

  logic is_end, is_delay, delay_zero, at_last, idle_like;
  logic entry_ok, entry_fail, go_read, retry_left, advance;
  state_t adv_target;

`ifdef CFG_READBACK_EN
  logic rd_phase;
`else
  logic unused_rdata;
  assign unused_rdata = ^sccb_rdata;
`endif

  assign is_end     = (rom_data == 16'hFFFF);
  assign is_delay   = (rom_data[15:8] == 8'hFF);
  assign delay_zero = (rom_data[7:0] == 8'h00);
  assign at_last    = (rom_addr == '1);
  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign retry_left = (retries < RET_W'(MAX_RETRY));
  assign adv_target = at_last ? S_DONE : S_FETCH;

  // Classify the SCCB completion; with readback a write ACK only moves on to the verify read.
  always_comb begin
    entry_ok   = 1'b0;
    entry_fail = 1'b0;
    go_read    = 1'b0;
    if (state == S_WAIT && sccb_done) begin
`ifdef CFG_READBACK_EN
      if (sccb_nack)                  entry_fail = 1'b1;
      else if (!rd_phase)             go_read    = 1'b1;
      else if (sccb_rdata == sccb_wdata) entry_ok = 1'b1;
      else                            entry_fail = 1'b1;
`else
      if (sccb_nack) entry_fail = 1'b1;
      else           entry_ok   = 1'b1;
`endif
    end
  end

  assign advance = entry_ok
                || (state == S_DECODE && !is_end && is_delay && delay_zero)
                || (state == S_DELAY && cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (is_end)          next_state = S_DONE;
        else if (is_delay)   next_state = delay_zero ? adv_target : S_DELAY;
        else                 next_state = S_ISSUE;
      end
      S_ISSUE:  if (sccb_ready) next_state = S_WAIT;
      S_WAIT: begin
        if (go_read)         next_state = S_ISSUE;
        else if (entry_ok)   next_state = adv_target;
        else if (entry_fail) next_state = retry_left ? S_ISSUE : S_ERROR;
      end
      S_DELAY:  if (cnt == '0) next_state = adv_target;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = !idle_like;
    cfg_done  = (state == S_DONE);
    cfg_error = (state == S_ERROR);
    sccb_req  = (state == S_ISSUE);
`ifdef CFG_READBACK_EN
    sccb_rw   = rd_phase;
`else
    sccb_rw   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr   <= '0;
      sccb_reg   <= '0;
      sccb_wdata <= '0;
      err_index  <= '0;
      cnt        <= '0;
      retries    <= '0;
`ifdef CFG_READBACK_EN
      rd_phase   <= 1'b0;
`endif
    end else begin
      if (idle_like && start) begin
        rom_addr <= '0;
        retries  <= '0;
      end
      if (advance) begin
        retries <= '0;
        if (!at_last) rom_addr <= rom_addr + 1'b1;
      end
      if (state == S_DECODE) begin
        if (is_delay) begin
          cnt <= CNT_W'(rom_data[7:0]) * CNT_W'(DELAY_UNIT);
        end else begin
          sccb_reg   <= rom_data[15:8];
          sccb_wdata <= rom_data[7:0];
        end
      end
      if (state == S_DELAY && cnt != '0) cnt <= cnt - 1'b1;
      if (entry_fail) begin
        if (retry_left) retries   <= retries + 1'b1;
        else            err_index <= rom_addr;
      end
`ifdef CFG_READBACK_EN
      // A failed read restarts the entry from its write.
      if (go_read)                              rd_phase <= 1'b1;
      else if (entry_fail || state == S_DECODE) rd_phase <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Bench for ov7670_cfg_sequencer: ROM and SCCB master models, transaction scoreboard, vector table.
module tb_ov7670_cfg_sequencer;

  localparam int unsigned AW = 2;
  localparam int unsigned DU = 10;
  localparam int unsigned MR = 3;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] rom_addr, err_index;
  logic [15:0]   rom_data;
  logic          sccb_req, sccb_ready, sccb_rw, sccb_done, sccb_nack;
  logic [7:0]    sccb_reg, sccb_wdata, sccb_rdata;
  logic          busy, cfg_done, cfg_error;

  always #5 clk = ~clk;

  ov7670_cfg_sequencer #(.ROM_AW(AW), .DELAY_UNIT(DU), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_req(sccb_req), .sccb_ready(sccb_ready), .sccb_rw(sccb_rw),
    .sccb_reg(sccb_reg), .sccb_wdata(sccb_wdata),
    .sccb_done(sccb_done), .sccb_nack(sccb_nack), .sccb_rdata(sccb_rdata),
    .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .err_index(err_index)
  );

  typedef struct {
    logic [3:0][15:0] rom;
    int               nack_entry;
    int               nack_count;
    logic             exp_done;
    logic             exp_error;
    logic [1:0]       exp_err_index;
    logic [1:0]       exp_addr;
    int               exp_accepts;
    int               min_gap;
  } vec_t;

  vec_t             vecs[6];
  logic [16:0]      exp_q[$];
  longint           acc_t[$];
  logic [3:0][15:0] rom;
  logic [7:0]       regmem[256];
  int               total = 0;
  int               bad = 0;
  int               accepts = 0;
  int               nack_entry = 9;
  int               nack_left = 0;
  bit               hold_low = 1'b0;
  bit               corrupt = 1'b0;
  longint           cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][15:0] mk(input logic [15:0] e0, e1, e2, e3);
    logic [3:0][15:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  // Expected SCCB transactions {rw,reg,data} for a table under the bench's NACK/readback policy.
  task automatic build_exp(input logic [3:0][15:0] r, input int ne, input int nc);
    int         left;
    logic [15:0] e;
    bit         ok;
    left = nc;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      e = r[i];
      if (e == 16'hFFFF) return;
      if (e[15:8] != 8'hFF) begin
        for (int a = 0; a <= int'(MR); a++) begin
          ok = 1'b1;
          exp_q.push_back({1'b0, e});
          if (i == ne && left > 0) begin
            left--;
            ok = 1'b0;
          end
`ifdef CFG_READBACK_EN
          else begin
            exp_q.push_back({1'b1, e});
            if (corrupt) ok = 1'b0;
          end
`endif
          if (ok) break;
          if (a == int'(MR)) return;
        end
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rom_addr"},  32'(rom_addr),   32'd0);
    chk({tag, "_sccb_req"},  32'(sccb_req),   32'd0);
    chk({tag, "_sccb_rw"},   32'(sccb_rw),    32'd0);
    chk({tag, "_sccb_reg"},  32'(sccb_reg),   32'd0);
    chk({tag, "_wdata"},     32'(sccb_wdata), 32'd0);
    chk({tag, "_busy"},      32'(busy),       32'd0);
    chk({tag, "_cfg_done"},  32'(cfg_done),   32'd0);
    chk({tag, "_cfg_error"}, 32'(cfg_error),  32'd0);
    chk({tag, "_err_index"}, 32'(err_index),  32'd0);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit fin;
    fin = 1'b0;
    for (int c = 0; c < limit && !fin; c++) begin
      step();
      if (!busy) fin = 1'b1;
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL %s_timeout: busy still %0d after %0d cycles, required 0", tag, busy, limit);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Synchronous ROM: data reflects the address sampled on the previous edge.
  initial begin
    logic [AW-1:0] pa;
    pa = '0;
    rom_data = '0;
    forever begin
      @(posedge clk);
      #1;
      rom_data = rom[pa];
      pa = rom_addr;
    end
  end

  // SCCB master: accepts on req&&ready, completes 4 cycles later; NACKs writes per nack_entry/nack_left.
  initial begin
    bit          inflight, nk;
    int          lat;
    logic [7:0]  rl;
    logic [16:0] got;
    inflight = 1'b0; nk = 1'b0; lat = 0; rl = '0;
    sccb_done = 1'b0; sccb_nack = 1'b0; sccb_rdata = '0; sccb_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (sccb_req && sccb_ready) begin
        got = {sccb_rw, sccb_reg, sccb_wdata};
        accepts++;
        acc_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got txn %0h, required none", got);
        end else begin
          chk("sb_txn", 32'(got), 32'(exp_q.pop_front()));
        end
        rl = sccb_reg;
        nk = !sccb_rw && (int'(rom_addr) == nack_entry) && (nack_left > 0);
        if (nk) nack_left--;
        if (!sccb_rw && !nk) regmem[rl] = sccb_wdata;
        inflight = 1'b1;
        lat = 3;
      end
      @(posedge clk);
      #1;
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      if (inflight) begin
        if (lat == 0) begin
          sccb_done  = 1'b1;
          sccb_nack  = nk;
          sccb_rdata = corrupt ? 8'h00 : regmem[rl];
          inflight   = 1'b0;
        end else begin
          lat--;
        end
      end
      sccb_ready = !inflight && !hold_low;
    end
  end

  task automatic run_vec(input int k, input vec_t v);
    string t;
    t = $sformatf("v%0d", k);
    rom = v.rom;
    nack_entry = v.nack_entry;
    nack_left = v.nack_count;
    corrupt = 1'b0;
    build_exp(v.rom, v.nack_entry, v.nack_count);
    accepts = 0;
    acc_t.delete();
    pulse_start();
    chk({t, "_start_busy"},  32'(busy),      32'd1);
    chk({t, "_start_addr"},  32'(rom_addr),  32'd0);
    chk({t, "_start_done"},  32'(cfg_done),  32'd0);
    chk({t, "_start_error"}, 32'(cfg_error), 32'd0);
    wait_idle(t, 3000);
    chk({t, "_cfg_done"},  32'(cfg_done),  32'(v.exp_done));
    chk({t, "_cfg_error"}, 32'(cfg_error), 32'(v.exp_error));
    chk({t, "_rom_addr"},  32'(rom_addr),  32'(v.exp_addr));
    if (v.exp_error) chk({t, "_err_index"}, 32'(err_index), 32'(v.exp_err_index));
    chk({t, "_sb_missing"}, 32'(exp_q.size()), 32'd0);
`ifndef CFG_READBACK_EN
    chk({t, "_accepts"}, 32'(accepts), 32'(v.exp_accepts));
    if (v.min_gap > 0 && acc_t.size() >= 2)
      chk({t, "_gap_ok"}, 32'((acc_t[1] - acc_t[0]) >= longint'(v.min_gap)), 32'd1);
`endif
    repeat (8) step();
  endtask

  initial begin
    bit stable, seen;
    vecs[0] = '{mk(16'h1280, 16'hFF01, 16'h1101, 16'hFFFF), 9, 0,  1'b1, 1'b0, 2'd0, 2'd3, 2, 10};
    vecs[1] = '{mk(16'h1280, 16'h3A04, 16'h1101, 16'hFFFF), 2, 2,  1'b1, 1'b0, 2'd0, 2'd3, 5, 0};
    vecs[2] = '{mk(16'h1280, 16'h1101, 16'h3A04, 16'hFFFF), 1, 99, 1'b0, 1'b1, 2'd1, 2'd1, 5, 0};
    vecs[3] = '{mk(16'h1280, 16'h1101, 16'h3A04, 16'h6B4A), 9, 0,  1'b1, 1'b0, 2'd0, 2'd3, 4, 0};
    vecs[4] = '{mk(16'hFF00, 16'h1280, 16'hFFFF, 16'h0000), 9, 0,  1'b1, 1'b0, 2'd0, 2'd2, 1, 0};
    vecs[5] = '{mk(16'hFFFF, 16'h1280, 16'h1280, 16'h1280), 9, 0,  1'b1, 1'b0, 2'd0, 2'd0, 0, 0};

    rom = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk_reset("reset");

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Ready held low: request must persist with stable fields, start ignored while busy.
    rom = mk(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    nack_left = 0;
    build_exp(rom, 9, 0);
    accepts = 0;
    hold_low = 1'b1;
    repeat (2) step();
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (sccb_req) seen = 1'b1;
      else step();
    end
    chk("hold_req_seen", 32'(sccb_req), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      step();
      if (!(sccb_req && sccb_reg == 8'h12 && sccb_wdata == 8'h80 && rom_addr == 2'd0 && busy))
        stable = 1'b0;
    end
    start = 1'b0;
    chk("hold_stable", 32'(stable), 32'd1);
    chk("hold_no_accept", 32'(accepts), 32'd0);
    hold_low = 1'b0;
    wait_idle("hold", 200);
    chk("hold_accepts", 32'(accepts), 32'(1 `ifdef CFG_READBACK_EN + 1 `endif));
    chk("hold_done", 32'(cfg_done), 32'd1);
    repeat (8) step();

    // Reset while waiting for the SCCB completion.
    rom = mk(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    build_exp(rom, 9, 0);
    accepts = 0;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      step();
      if (accepts == 1) seen = 1'b1;
    end
    chk("rstwait_accepted", 32'(accepts), 32'd1);
    chk("rstwait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rstwait");
    repeat (10) step();
    chk("rstwait_stays_idle", 32'(busy), 32'd0);
    exp_q.delete();

`ifdef CFG_READBACK_EN
    rom = mk(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    corrupt = 1'b1;
    nack_left = 0;
    build_exp(rom, 9, 0);
    accepts = 0;
    pulse_start();
    wait_idle("rb", 1000);
    chk("rb_error", 32'(cfg_error), 32'd1);
    chk("rb_err_index", 32'(err_index), 32'd0);
    chk("rb_accepts", 32'(accepts), 32'(2 * (MR + 1)));
    chk("rb_sb_missing", 32'(exp_q.size()), 32'd0);
    corrupt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
